// File: rtl/path_planner_bfs.sv
// Minimum-hop path planner: breadth-first search over a run-time loadable
// directed adjacency matrix, reporting the path end-node first.
module path_planner_bfs #(
  parameter int NODES    = 27,
  parameter int NODE_W   = 5,
  parameter int MAX_PATH = 10,
  parameter int FILL     = 27
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NODE_W-1:0]            s_node,
  input  logic [NODE_W-1:0]            e_node,
  input  logic                         adj_we,
  input  logic [NODE_W-1:0]            adj_addr,
  input  logic [NODES-1:0]             adj_wdata,
  output logic                         done,
  output logic                         error,
  output logic [MAX_PATH*NODE_W-1:0]   final_path
);

  localparam int PW = MAX_PATH * NODE_W;
  localparam int KW = $clog2(MAX_PATH + 1);
  localparam logic [NODE_W-1:0] NODES_L = NODE_W'(NODES);
  localparam logic [NODE_W-1:0] LAST_L  = NODE_W'(NODES - 1);
  localparam logic [NODE_W-1:0] FILL_L  = NODE_W'(FILL);
  localparam logic [KW-1:0]     MAXP_L  = KW'(MAX_PATH);
  localparam logic [PW-1:0]     ALLF    = {MAX_PATH{FILL_L}};
  localparam logic [NODES-1:0]  ONE     = {{(NODES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, INIT, POP, SCAN, TRACE, ERR
  } state_t;

  state_t state_q, state_d;

  logic [NODES-1:0]  adj_q    [NODES];
  logic [NODE_W-1:0] parent_q [NODES];
  logic [NODE_W-1:0] queue_q  [NODES];
  logic [NODES-1:0]  visited_q;
  logic [NODE_W-1:0] head_q, tail_q;
  logic [NODE_W-1:0] cur_q, j_q;
  logic [NODE_W-1:0] s_q, e_q, t_node_q;
  logic [KW-1:0]     k_q;
  logic [PW-1:0]     shadow_q, shadow_w, path_q;
  logic              start_q, done_q, err_q;

  logic start_acc, bad_ep, q_empty;
  logic nbr, hit, k_over, at_src;

  assign start_acc = start & ~start_q & (state_q == IDLE);
  assign bad_ep    = (s_q >= NODES_L) | (e_q >= NODES_L);
  assign q_empty   = (head_q == tail_q);
  assign nbr       = adj_q[cur_q][j_q] & ~visited_q[j_q];
  assign hit       = nbr & (j_q == e_q);
  assign k_over    = (k_q >= MAXP_L);
  assign at_src    = (t_node_q == s_q);

  assign done       = done_q;
  assign error      = err_q;
  assign final_path = path_q;

  // Shadow path with the current trace slot merged in.
  always_comb begin
    shadow_w = shadow_q;
    if (!k_over)
      shadow_w[k_q*NODE_W +: NODE_W] = t_node_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_acc) state_d = INIT;
      INIT: begin
        if (bad_ep)          state_d = ERR;
        else if (s_q == e_q) state_d = TRACE;
        else                 state_d = POP;
      end
      POP:   state_d = q_empty ? ERR : SCAN;
      SCAN: begin
        if (hit)                 state_d = TRACE;
        else if (j_q == LAST_L)  state_d = POP;
      end
      TRACE: begin
        if (k_over)      state_d = ERR;
        else if (at_src) state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NODES; i++) begin
        adj_q[i]    <= '0;
        parent_q[i] <= '0;
        queue_q[i]  <= '0;
      end
      visited_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cur_q     <= '0;
      j_q       <= '0;
      s_q       <= '0;
      e_q       <= '0;
      t_node_q  <= '0;
      k_q       <= '0;
      shadow_q  <= '0;
      path_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      start_q <= start;
      unique case (state_q)
        IDLE: begin
          if (adj_we && adj_addr < NODES_L)
            adj_q[adj_addr] <= adj_wdata;
          if (start_acc) begin
            s_q    <= s_node;
            e_q    <= e_node;
            done_q <= 1'b0;
          end
        end
        INIT: begin
          // Shift yields an empty mask for an out-of-range start node.
          visited_q <= ONE << s_q;
          for (int i = 0; i < NODES; i++)
            parent_q[i] <= '0;
          queue_q[0] <= s_q;
          head_q     <= '0;
          tail_q     <= NODE_W'(1);
          t_node_q   <= e_q;
          k_q        <= '0;
          shadow_q   <= ALLF;
        end
        POP: begin
          if (!q_empty) begin
            cur_q  <= queue_q[head_q];
            head_q <= head_q + 1'b1;
            j_q    <= '0;
          end
        end
        SCAN: begin
          if (nbr) begin
            visited_q[j_q] <= 1'b1;
            parent_q[j_q]  <= cur_q;
            queue_q[tail_q] <= j_q;
            tail_q <= tail_q + 1'b1;
          end
          j_q <= j_q + 1'b1;
        end
        TRACE: begin
          if (!k_over) begin
            shadow_q <= shadow_w;
            if (at_src) begin
              path_q <= shadow_w;
              err_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              t_node_q <= parent_q[t_node_q];
              k_q      <= k_q + 1'b1;
            end
          end
        end
        ERR: begin
          path_q <= ALLF;
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_path_planner_bfs.sv
// Scoreboard bench for path_planner_bfs: directed searches push expected
// results; a monitor pops and compares on each done rising edge.
module tb_path_planner_bfs;

  localparam int NODES = 27;
  localparam int NW    = 5;
  localparam int MP    = 10;
  localparam int FILL  = 27;
  localparam int PW    = MP * NW;
  localparam int BOUND = NODES * (NODES + 1) + MP + 4;

  logic clk = 1'b0;
  logic reset, start, adj_we;
  logic [NW-1:0] s_node, e_node, adj_addr;
  logic [NODES-1:0] adj_wdata;
  logic done, error;
  logic [PW-1:0] final_path;

  always #5 clk = ~clk;

  path_planner_bfs #(
    .NODES(NODES), .NODE_W(NW),
    .MAX_PATH(MP), .FILL(FILL)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_node(s_node), .e_node(e_node),
    .adj_we(adj_we), .adj_addr(adj_addr),
    .adj_wdata(adj_wdata),
    .done(done), .error(error),
    .final_path(final_path)
  );

  typedef struct packed {
    logic          err;
    logic [PW-1:0] path;
  } exp_t;

  exp_t sb[$];
  int   pth[$];
  int   errors = 0;
  int   checks = 0;
  int   falls  = 0;
  logic prev_done = 1'b1;
  logic [PW-1:0] allf;

  task automatic chk(input string name,
                     input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkp();
    logic [PW-1:0] v;
    v = {MP{NW'(FILL)}};
    for (int i = 0; i < pth.size(); i++)
      v[i*NW +: NW] = NW'(pth[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b1;
    end else begin
      exp_t x;
      if (prev_done && !done) falls++;
      if (!prev_done && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want none");
        end else begin
          x = sb.pop_front();
          chk("error", PW'(error), PW'(x.err));
          chk("path", final_path, x.path);
        end
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic er);
    exp_t x;
    x.err  = er;
    x.path = er ? allf : mkp();
    sb.push_back(x);
  endtask

  task automatic write_row(input int a,
                           input logic [NODES-1:0] d);
    adj_we    = 1'b1;
    adj_addr  = NW'(a);
    adj_wdata = d;
    tick();
    adj_we = 1'b0;
  endtask

  task automatic run(input int s, input int e,
                     input logic er, input bit inj,
                     output int lat);
    push_exp(er);
    s_node = NW'(s);
    e_node = NW'(e);
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("done_fall", PW'(done), PW'(0));
    lat = 1;
    while (!done && lat < BOUND) begin
      if (inj && lat == 3) begin
        adj_we    = 1'b1;
        adj_addr  = '0;
        adj_wdata = NODES'(1) << 9;
      end else begin
        adj_we = 1'b0;
      end
      tick();
      lat++;
    end
    adj_we = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done=0 want done=1");
      void'(sb.pop_back());
    end
    tick();
  endtask

  initial begin
    int lat, f0;
    allf = {MP{NW'(FILL)}};
    reset = 1'b1; start = 1'b0; adj_we = 1'b0;
    s_node = '0; e_node = '0;
    adj_addr = '0; adj_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_done", PW'(done), PW'(1));
    chk("rst_error", PW'(error), PW'(0));
    chk("rst_path", final_path, '0);

    // Empty graph: unreachable.
    pth = {};
    run(0, 5, 1'b1, 1'b0, lat);

    write_row(0, (NODES'(1) << 2) | (NODES'(1) << 1));
    write_row(2, NODES'(1) << 4);
    write_row(4, NODES'(1) << 10);
    write_row(10, NODES'(1) << 9);
    write_row(1, NODES'(1) << 9);
    pth = '{9, 1, 0};
    run(0, 9, 1'b0, 1'b0, lat);

    write_row(1, '0);
    pth = '{9, 10, 4, 2, 0};
    run(0, 9, 1'b0, 1'b0, lat);

    pth = '{11};
    run(11, 11, 1'b0, 1'b0, lat);
    chk("lat_same", PW'(lat <= 6), PW'(1));

    // Chain 0->1->...->12: 13 nodes exceed the slot count.
    for (int k = 0; k < 12; k++)
      write_row(k, NODES'(1) << (k + 1));
    run(0, 12, 1'b1, 1'b0, lat);

    run(28, 0, 1'b1, 1'b0, lat);

    // Exactly MAX_PATH nodes; a write during search must be lost.
    pth = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    run(0, 9, 1'b0, 1'b1, lat);
    run(0, 9, 1'b0, 1'b0, lat);

    // Start held high across completion.
    pth = '{5, 4, 3, 2, 1, 0};
    push_exp(1'b0);
    f0 = falls;
    s_node = '0;
    e_node = NW'(5);
    start = 1'b1;
    tick();
    chk("hold_fall", PW'(done), PW'(0));
    repeat (200) tick();
    start = 1'b0;
    tick();
    chk("hold_once", PW'(falls - f0), PW'(1));
    chk("hold_done", PW'(done), PW'(1));

    // Reset in the middle of a long search.
    e_node = NW'(12);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("mid_busy", PW'(done), PW'(0));
    reset = 1'b1;
    tick();
    chk("mid_done", PW'(done), PW'(1));
    chk("mid_path", final_path, '0);
    chk("mid_error", PW'(error), PW'(0));
    reset = 1'b0;
    tick();

    // Adjacency was cleared by reset.
    run(0, 1, 1'b1, 1'b0, lat);

    chk("sb_empty", PW'(sb.size()), PW'(0));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/path_planner_bfs.md
Name: path_planner_bfs

Overview:
- Parametrised successor to the fixed-graph path planner.
- Finds a minimum-hop path between two nodes of a directed graph by breadth-first search (BFS).
- The adjacency matrix is loadable at run time, so the graph is not hard-wired.
- Reports the path as packed node indices, end node in slot 0, plus explicit error reporting.
- Sits between the arena map loader and the bot motion sequencer.

Parameters:
NODES, 27, number of graph nodes (indices 0..NODES-1)
NODE_W, 5, bits per node index; 2^NODE_W > NODES
MAX_PATH, 10, path slots in final_path (max nodes incl. start and end)
FILL, 27, code placed in unused path slots; FILL >= NODES

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  request; accepted on rising edge (start=1, previous-cycle start=0) while idle
s_node  in  NODE_W  start node, sampled when start accepted
e_node  in  NODE_W  end node, sampled when start accepted
adj_we  in  1  adjacency row write enable
adj_addr  in  NODE_W  source node of row
adj_wdata  in  NODES  bit j=1 => directed edge adj_addr->j
done  out  1  high when idle/result valid, low while busy
error  out  1  last search failed (valid when done=1)
final_path  out  MAX_PATH*NODE_W  slot k at bits [k*NODE_W +: NODE_W]

Behaviour:
- Reset values: done=1, error=0, final_path=0, FSM=IDLE, adjacency all 0, start edge-detect register 0.
- Adjacency writes:
  - Take effect the next cycle, only in IDLE.
  - Ignored when adj_addr >= NODES.
  - Ignored while busy; the graph is frozen during a search.
- FSM: IDLE -> INIT -> SEARCH -> TRACE -> IDLE, with ERR -> IDLE as the failure path.
- IDLE:
  - done=1; outputs hold the last result.
  - On an accepted start: latch s_node/e_node, go INIT; done=0 from the next cycle.
  - Start held high does not retrigger.
  - Start pulses while busy are ignored.
- INIT (1 cycle):
  - Clear the visited mask and parent array.
  - Push s_node onto the queue (depth NODES) and mark it visited.
  - If s_node>=NODES or e_node>=NODES, go ERR.
  - If s_node==e_node, go TRACE.
- SEARCH:
  - Pop a node, then scan its adjacency row one bit per cycle, ascending j=0..NODES-1.
  - For each unvisited neighbour: mark visited, set parent[j]=current, push j.
  - Ascending scan makes the tie-break deterministic: among equal-hop paths, the lowest-index neighbour is discovered first.
  - When e_node is marked visited, go TRACE immediately; the rest of the row is not scanned.
  - Queue empty with e_node unvisited: go ERR (unreachable).
- TRACE:
  - Walk parents from e_node, writing one slot per cycle into a shadow path register.
  - Slot 0=e_node, slot 1=parent(e_node), ... until s_node is written.
  - Remaining slots are FILL.
  - If s_node would need slot index >= MAX_PATH, go ERR (path too long).
  - On completion: copy the shadow register to final_path, error=0, done=1 in the same cycle, go IDLE.
- ERR: final_path = all slots FILL, error=1, done=1, go IDLE.
- final_path changes only on the done 0->1 transition; it is stable throughout a search.
- Latency from accepted start to done=1 is bounded by NODES*(NODES+1)+MAX_PATH+4 cycles.
- Reset mid-search: abort, return to reset values; adjacency is cleared.

Test Plan:
- Reset, then start with s=0, e=5 on an empty graph -> done falls next cycle, then error=1, final_path = 10 slots of 27, done=1.
- Load edges 0->2, 2->4, 4->10, 10->9, 0->1, 1->9 (rows written in IDLE); start s=0, e=9 -> final_path slots 9,1,0 then 7x27, error=0.
- Same graph, remove edge 1->9 (rewrite row 1=0); s=0, e=9 -> slots 9,10,4,2,0 then 5x27.
- s=e=11 -> slots 11 then 9x27, error=0, done within 6 cycles.
- Chain 0->1->...->12 (12 hops, 13 nodes > MAX_PATH=10); s=0, e=12 -> error=1, all FILL.
- Start held high for 200 cycles across completion -> exactly one search. adj_we during SEARCH -> ignored, result unchanged. Reset asserted mid-SEARCH -> done=1, final_path=0 next cycle.
